ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
ID/EX pipeline register and operand-select stage that feeds the ALU in the 5-stage RV32I pipeline. Captures decoded fields each cycle and forwards results from the EX/MEM and MEM/WB stages onto the ALU operands. Detects load-use hazards, stalling fetch/decode and inserting a bubble. Takes the branch-flush from EX.

Parameters:
DATA_WIDTH, 32, datapath width
ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
id_valid  in  1  decode slot holds a real instruction
id_rs1_data, id_rs2_data, id_imm, id_pc  in  DATA_WIDTH each  decoded operands
id_rs1, id_rs2, id_rd  in  ADDR_WIDTH each  register indices
id_alu_ctrl  in  3  ALU op code
id_op1_sel  in  1  0=rs1, 1=pc
id_op2_sel  in  1  0=rs2, 1=imm
id_reg_write, id_mem_read, id_mem_write  in  1 each  control
flush  in  1  branch taken in EX; kill the decode instruction
exm_rd  in  ADDR_WIDTH  EX/MEM destination
exm_reg_write  in  1  EX/MEM writes rd
exm_result  in  DATA_WIDTH  EX/MEM ALU result
wb_rd  in  ADDR_WIDTH  MEM/WB destination
wb_reg_write  in  1  MEM/WB writes rd
wb_result  in  DATA_WIDTH  MEM/WB writeback value
stall  out  1  hold PC and IF/ID this cycle
ALUop1, ALUop2  out  DATA_WIDTH  ALU operands
ALUctrl  out  3  registered ALU op
ex_store_data  out  DATA_WIDTH  forwarded rs2 for stores
ex_rd  out  ADDR_WIDTH  registered rd
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control

Behaviour:
- Reset (async, rst=1): all ID/EX registers cleared, so ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, ALUctrl=0, ex_rd=0, ex_store_data=0, stall=0, ALUop1=ALUop2=0. Deassertion is synchronous to the next clk edge. Reset mid-stall drops the held instruction.
- Latency: the decode instruction appears on the ex_* outputs one cycle after capture. ALUop1, ALUop2 and ex_store_data are combinational from the registered fields plus the forward inputs, with no extra cycle.
- Load-use hazard: stall=1 when all of the following hold:
  - id_valid=1 and ex_valid=1 and ex_mem_read=1
  - ex_rd!=0
  - ex_rd==id_rs1, or ex_rd==id_rs2 (the rs2 match counts only when id_op2_sel=0 or id_mem_write=1)
- On a stall cycle the register loads a bubble: ex_valid, ex_reg_write, ex_mem_read and ex_mem_write are all 0. Datapath fields are don't-care.
- Flush has priority over stall. With flush=1, stall=0 and the register loads a bubble.
- Otherwise the register loads the id_* fields. When id_valid=0 all control bits are forced to 0.
- Forwarding, per source rs1 and rs2 independently, highest priority first:
  - If exm_reg_write=1, exm_rd!=0 and exm_rd matches the source, use exm_result.
  - Else if wb_reg_write=1, wb_rd!=0 and wb_rd matches the source, use wb_result.
  - Else use the registered register-file data.
- Register x0 is never forwarded. The register file writes before it reads, so no three-stage-back forwarding is needed.
- Operand select:
  - ALUop1 = forwarded rs1, or the registered pc when op1_sel=1.
  - ALUop2 = forwarded rs2, or the registered imm when op2_sel=1.
  - ex_store_data is always the forwarded rs2.
- Width: all operands are DATA_WIDTH with no extension inside this block. The immediate arrives already sign-extended.

Optional Feature:
Macro EX_FWD_EN.
- Defined: forwarding behaves as described above.
- Undefined: the forwarding muxes are removed and operands use the registered register-file data only. The stall condition is extended to any id_rs1/id_rs2 match (x0 excluded, rs2 qualified as above) against either of these:
  - ex_rd when ex_valid=1 and ex_reg_write=1
  - exm_rd when exm_reg_write=1
- Stall cycles then insert bubbles exactly as for a load-use hazard.

Test Plan:
1. Reset mid-operation: assert rst with ex_valid=1 → ex_valid=0, stall=0 and ALUop1=0 immediately, without waiting for a clock edge.
2. EX/MEM forward: ex rs1=5; exm_rd=5, exm_reg_write=1, exm_result=0x10; registered rs1_data=0x99 → ALUop1=0x10. With wb_rd=5, wb_result=0x20 also asserted, ALUop1 is still 0x10.
3. x0 guard: exm_rd=0, exm_reg_write=1, exm_result=0xFFFF, ex rs2=0, op2_sel=0 → ALUop2 equals the registered rs2_data (0).
4. Load-use: ex is lw with rd=7; id is add reading rs2=7 → stall=1 for exactly one cycle; next cycle ex_valid=0. The following cycle the add enters EX with ALUop2=wb_result.
5. Flush plus hazard: flush=1 in the same cycle as a load-use match → stall=0; next cycle ex_valid=0 and ex_reg_write=0.
6. Without EX_FWD_EN: back-to-back add x3 then sub reading x3 → stall=1 for 2 cycles. The sub then sees the register-file value once it is written.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// -----------------------------------------------------------------------------
// ex_operand_stage_if
//
// Purpose:
//   Decode-to-execute bundle for the RV32I pipeline. Carries the decoded
//   instruction fields from the ID stage into the ID/EX register and returns
//   the load-use stall request back to fetch/decode.
//
// Parameters:
//   DATA_WIDTH - datapath width (default 32)
//   ADDR_WIDTH - register index width (default 5)
//
// Signals:
//   id_valid                 decode slot holds a real instruction
//   id_rs1_data/id_rs2_data  register-file read data
//   id_imm                   sign-extended immediate
//   id_pc                    instruction address
//   id_rs1/id_rs2/id_rd      register indices
//   id_alu_ctrl              ALU op code
//   id_op1_sel               0 = rs1, 1 = pc
//   id_op2_sel               0 = rs2, 1 = imm
//   id_reg_write/id_mem_read/id_mem_write  control bits
//   stall                    hold PC and IF/ID this cycle
//
// Modports:
//   master - decode stage (drives id_*, receives stall)
//   slave  - operand stage (receives id_*, drives stall)
// -----------------------------------------------------------------------------
interface ex_operand_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_rs1_data;
    logic [DATA_WIDTH-1:0] id_rs2_data;
    logic [DATA_WIDTH-1:0] id_imm;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [ADDR_WIDTH-1:0] id_rs1;
    logic [ADDR_WIDTH-1:0] id_rs2;
    logic [ADDR_WIDTH-1:0] id_rd;
    logic [2:0]            id_alu_ctrl;
    logic                  id_op1_sel;
    logic                  id_op2_sel;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  stall;

    modport master (
        output id_valid, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_op1_sel, id_op2_sel,
               id_reg_write, id_mem_read, id_mem_write,
        input  stall
    );

    modport slave (
        input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_op1_sel, id_op2_sel,
               id_reg_write, id_mem_read, id_mem_write,
        output stall
    );
endinterface

// File: rtl/ex_operand_stage.sv
// -----------------------------------------------------------------------------
// ex_operand_stage
//
// Purpose:
//   ID/EX pipeline register and ALU operand-select stage of the 5-stage RV32I
//   pipeline. Captures the decoded instruction each cycle, forwards EX/MEM and
//   MEM/WB results onto the ALU operands, detects data hazards that require a
//   stall, and turns stall/branch-flush cycles into bubbles.
//
// Configuration macro:
//   EX_FWD_EN - defined: EX/MEM and MEM/WB forwarding muxes are present and
//               only load-use hazards stall.
//               undefined (default): no forwarding; any read-after-write
//               against the EX or EX/MEM destination stalls instead.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   id_bus          decode bundle (slave side), includes the stall output
//   flush           branch taken in EX; kill the decode instruction
//   exm_rd/exm_reg_write/exm_result   EX/MEM destination and result
//   wb_rd/wb_reg_write/wb_result      MEM/WB destination and writeback value
//   ALUop1, ALUop2  ALU operands (combinational from registered fields)
//   ALUctrl         registered ALU op
//   ex_store_data   forwarded rs2 for stores
//   ex_rd           registered destination
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  registered control
// -----------------------------------------------------------------------------
module ex_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    ex_operand_stage_if.slave     id_bus,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] exm_rd,
    input  logic                  exm_reg_write,
    input  logic [DATA_WIDTH-1:0] exm_result,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write
);

    // Registered datapath fields
    logic [DATA_WIDTH-1:0] rs1_data_q;
    logic [DATA_WIDTH-1:0] rs2_data_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  op1_sel_q;
    logic                  op2_sel_q;

    // Forwarded source operands
    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;

    // Hazard detection
    logic use_rs2;
    logic load_use;
    logic hazard;
    logic stall_int;
    logic bubble;

    // A destination matches a source only if it is a real register (x0 is
    // hard-wired zero and never produces a dependency).
    function automatic logic reg_match(
        input logic [ADDR_WIDTH-1:0] dst,
        input logic [ADDR_WIDTH-1:0] src
    );
        return (dst != '0) && (dst == src);
    endfunction

    // rs2 is only a true dependency when the ALU consumes it or a store
    // needs it as write data; immediate-form ALU ops ignore it.
    assign use_rs2 = !id_bus.id_op2_sel || id_bus.id_mem_write;

    // A load in EX cannot forward in time: its data only exists after MEM.
    assign load_use = ex_valid && ex_mem_read &&
                      (reg_match(ex_rd, id_bus.id_rs1) ||
                       (use_rs2 && reg_match(ex_rd, id_bus.id_rs2)));

`ifdef EX_FWD_EN
    assign hazard = id_bus.id_valid && load_use;
`else
    logic raw_ex;
    logic raw_exm;

    // Without forwarding, any producer still in EX or EX/MEM must retire to
    // the register file before the consumer may read it.
    assign raw_ex  = ex_valid && ex_reg_write &&
                     (reg_match(ex_rd, id_bus.id_rs1) ||
                      (use_rs2 && reg_match(ex_rd, id_bus.id_rs2)));

    assign raw_exm = exm_reg_write &&
                     (reg_match(exm_rd, id_bus.id_rs1) ||
                      (use_rs2 && reg_match(exm_rd, id_bus.id_rs2)));

    assign hazard = id_bus.id_valid && (load_use || raw_ex || raw_exm);
`endif

    // Flush wins over stall: the decode instruction is being killed anyway,
    // so there is nothing to hold.
    assign stall_int    = hazard && !flush;
    assign bubble       = flush || stall_int;
    assign id_bus.stall = stall_int && !rst;

    // ID/EX register. Control bits are zeroed for bubbles and for empty
    // decode slots; datapath fields load unconditionally since a bubble
    // never uses them.
`ifdef EX_FWD_EN
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            rs1_q <= id_bus.id_rs1;
            rs2_q <= id_bus.id_rs2;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ALUctrl      <= '0;
            ex_rd        <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            op1_sel_q    <= 1'b0;
            op2_sel_q    <= 1'b0;
        end else begin
            ex_valid     <= id_bus.id_valid && !bubble;
            ex_reg_write <= id_bus.id_valid && !bubble && id_bus.id_reg_write;
            ex_mem_read  <= id_bus.id_valid && !bubble && id_bus.id_mem_read;
            ex_mem_write <= id_bus.id_valid && !bubble && id_bus.id_mem_write;
            ALUctrl      <= id_bus.id_alu_ctrl;
            ex_rd        <= id_bus.id_rd;
            rs1_data_q   <= id_bus.id_rs1_data;
            rs2_data_q   <= id_bus.id_rs2_data;
            imm_q        <= id_bus.id_imm;
            pc_q         <= id_bus.id_pc;
            op1_sel_q    <= id_bus.id_op1_sel;
            op2_sel_q    <= id_bus.id_op2_sel;
        end
    end

`ifdef EX_FWD_EN
    // The younger producer (EX/MEM) holds the newer value, so it takes
    // priority over MEM/WB. Older results are already in the register file
    // because it writes before it reads.
    always_comb begin
        rs1_fwd = rs1_data_q;
        if (exm_reg_write && reg_match(exm_rd, rs1_q)) begin
            rs1_fwd = exm_result;
        end else if (wb_reg_write && reg_match(wb_rd, rs1_q)) begin
            rs1_fwd = wb_result;
        end
    end

    always_comb begin
        rs2_fwd = rs2_data_q;
        if (exm_reg_write && reg_match(exm_rd, rs2_q)) begin
            rs2_fwd = exm_result;
        end else if (wb_reg_write && reg_match(wb_rd, rs2_q)) begin
            rs2_fwd = wb_result;
        end
    end
`else
    logic unused_fwd_inputs;

    // Result buses feed only the forwarding muxes, which this build omits.
    assign unused_fwd_inputs = ^{exm_result, wb_rd, wb_reg_write, wb_result};

    assign rs1_fwd = rs1_data_q;
    assign rs2_fwd = rs2_data_q;
`endif

    assign ALUop1        = op1_sel_q ? pc_q  : rs1_fwd;
    assign ALUop2        = op2_sel_q ? imm_q : rs2_fwd;
    assign ex_store_data = rs2_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_operand_stage
//
// Purpose:
//   Directed testbench for ex_operand_stage. Walks through reset, forwarding
//   priority, the x0 guard, operand select, load-use stalls, flush priority,
//   rs2 qualification and the non-forwarding RAW stall. Expectations follow
//   the EX_FWD_EN macro so the same bench serves both builds.
// -----------------------------------------------------------------------------
module tb_ex_operand_stage;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic [4:0]  exm_rd;
    logic        exm_reg_write;
    logic [31:0] exm_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_result;
    logic [31:0] ALUop1;
    logic [31:0] ALUop2;
    logic [2:0]  ALUctrl;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;

    int total = 0;
    int bad   = 0;

    ex_operand_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) id_bus ();

    ex_operand_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_bus        (id_bus),
        .flush         (flush),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .ALUop1        (ALUop1),
        .ALUop2        (ALUop2),
        .ALUctrl       (ALUctrl),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic        valid,
        input logic [4:0]  rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic [31:0] rs1_data, input logic [31:0] rs2_data,
        input logic [31:0] imm, input logic [31:0] pc,
        input logic [2:0]  alu,
        input logic        op1_sel, input logic op2_sel,
        input logic        reg_write, input logic mem_read, input logic mem_write
    );
        id_bus.id_valid     = valid;
        id_bus.id_rs1       = rs1;
        id_bus.id_rs2       = rs2;
        id_bus.id_rd        = rd;
        id_bus.id_rs1_data  = rs1_data;
        id_bus.id_rs2_data  = rs2_data;
        id_bus.id_imm       = imm;
        id_bus.id_pc        = pc;
        id_bus.id_alu_ctrl  = alu;
        id_bus.id_op1_sel   = op1_sel;
        id_bus.id_op2_sel   = op2_sel;
        id_bus.id_reg_write = reg_write;
        id_bus.id_mem_read  = mem_read;
        id_bus.id_mem_write = mem_write;
    endtask

    task automatic idleDecode();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0,
                      3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic setExm(input logic [4:0] rd, input logic we, input logic [31:0] val);
        exm_rd        = rd;
        exm_reg_write = we;
        exm_result    = val;
    endtask

    task automatic setWb(input logic [4:0] rd, input logic we, input logic [31:0] val);
        wb_rd        = rd;
        wb_reg_write = we;
        wb_result    = val;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        idleDecode();
        setExm(5'd0, 1'b0, 32'h0);
        setWb(5'd0, 1'b0, 32'h0);
        #12;

        // Reset values
        checkOutput("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("rst_stall", {31'b0, id_bus.stall}, 32'h0);
        checkOutput("rst_aluop1", ALUop1, 32'h0);
        checkOutput("rst_aluop2", ALUop2, 32'h0);
        checkOutput("rst_aluctrl", {29'b0, ALUctrl}, 32'h0);
        checkOutput("rst_ex_rd", {27'b0, ex_rd}, 32'h0);
        checkOutput("rst_store", ex_store_data, 32'h0);
        rst = 1'b0;

        // Forwarding priority on rs1 (x5)
        applyStimulus(1'b1, 5'd5, 5'd6, 5'd8, 32'h99, 32'h66, 32'h44, 32'h100,
                      3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("no_stall_empty_ex", {31'b0, id_bus.stall}, 32'h0);
        step();
        idleDecode();
        #1;
        checkOutput("cap_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("cap_aluctrl", {29'b0, ALUctrl}, 32'h3);
        checkOutput("cap_rd", {27'b0, ex_rd}, 32'h8);
        checkOutput("cap_reg_write", {31'b0, ex_reg_write}, 32'h1);
        checkOutput("cap_mem_read", {31'b0, ex_mem_read}, 32'h0);
        checkOutput("cap_aluop1", ALUop1, 32'h99);
        checkOutput("cap_aluop2", ALUop2, 32'h66);
        setExm(5'd5, 1'b1, 32'h10);
        #1;
        checkOutput("fwd_exm_rs1", ALUop1, FWD ? 32'h10 : 32'h99);
        setWb(5'd5, 1'b1, 32'h20);
        #1;
        checkOutput("fwd_exm_over_wb", ALUop1, FWD ? 32'h10 : 32'h99);
        exm_reg_write = 1'b0;
        #1;
        checkOutput("fwd_wb_rs1", ALUop1, FWD ? 32'h20 : 32'h99);
        wb_rd = 5'd6;
        #1;
        checkOutput("fwd_wb_gone_rs1", ALUop1, 32'h99);
        checkOutput("fwd_wb_rs2", ALUop2, FWD ? 32'h20 : 32'h66);
        checkOutput("fwd_wb_store", ex_store_data, FWD ? 32'h20 : 32'h66);
        setExm(5'd0, 1'b0, 32'h0);
        setWb(5'd0, 1'b0, 32'h0);

        // x0 is never forwarded
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd4, 32'h5, 32'h0, 32'h7FF, 32'h104,
                      3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        idleDecode();
        setExm(5'd0, 1'b1, 32'hFFFF);
        setWb(5'd0, 1'b1, 32'h1234);
        #1;
        checkOutput("x0_aluop2", ALUop2, 32'h0);
        checkOutput("x0_store", ex_store_data, 32'h0);
        checkOutput("x0_aluop1", ALUop1, 32'h5);
        setExm(5'd0, 1'b0, 32'h0);
        setWb(5'd0, 1'b0, 32'h0);

        // pc / imm operand select
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h200,
                      3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        idleDecode();
        #1;
        checkOutput("sel_pc", ALUop1, 32'h200);
        checkOutput("sel_imm", ALUop2, 32'hFFFF_FFF0);

        // Load-use: lw x7 in EX, add reads x7 through rs2
        applyStimulus(1'b1, 5'd2, 5'd0, 5'd7, 32'h40, 32'h0, 32'h4, 32'h208,
                      3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 5'd1, 5'd7, 5'd9, 32'h11, 32'h77, 32'h0, 32'h20C,
                      3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("lu_stall", {31'b0, id_bus.stall}, 32'h1);
        step();
        setExm(5'd7, 1'b1, 32'h1000);
        #1;
        checkOutput("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("lu_bubble_mem_read", {31'b0, ex_mem_read}, 32'h0);
        checkOutput("lu_stall_2nd", {31'b0, id_bus.stall}, FWD ? 32'h0 : 32'h1);
`ifdef EX_FWD_EN
        step();
        setExm(5'd0, 1'b0, 32'h0);
        setWb(5'd7, 1'b1, 32'hABCD);
        idleDecode();
        #1;
        checkOutput("lu_add_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("lu_add_rd", {27'b0, ex_rd}, 32'h9);
        checkOutput("lu_add_aluop2", ALUop2, 32'hABCD);
        checkOutput("lu_add_aluop1", ALUop1, 32'h11);
`else
        step();
        setExm(5'd0, 1'b0, 32'h0);
        setWb(5'd7, 1'b1, 32'hABCD);
        id_bus.id_rs2_data = 32'hABCD;
        #1;
        checkOutput("lu_stall_3rd", {31'b0, id_bus.stall}, 32'h0);
        checkOutput("lu_bubble2_valid", {31'b0, ex_valid}, 32'h0);
        step();
        idleDecode();
        setWb(5'd0, 1'b0, 32'h0);
        #1;
        checkOutput("lu_add_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("lu_add_rd", {27'b0, ex_rd}, 32'h9);
        checkOutput("lu_add_aluop2", ALUop2, 32'hABCD);
`endif
        setExm(5'd0, 1'b0, 32'h0);
        setWb(5'd0, 1'b0, 32'h0);

        // Flush beats a load-use match
        applyStimulus(1'b1, 5'd3, 5'd0, 5'd7, 32'h40, 32'h0, 32'h4, 32'h210,
                      3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 5'd7, 5'd1, 5'd10, 32'h0, 32'h1, 32'h0, 32'h214,
                      3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        checkOutput("flush_no_stall", {31'b0, id_bus.stall}, 32'h0);
        step();
        flush = 1'b0;
        idleDecode();
        #1;
        checkOutput("flush_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("flush_reg_write", {31'b0, ex_reg_write}, 32'h0);

        // rs2 qualification with lw x7 in EX
        applyStimulus(1'b1, 5'd3, 5'd0, 5'd7, 32'h40, 32'h0, 32'h4, 32'h218,
                      3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 5'd1, 5'd7, 5'd11, 32'h0, 32'h0, 32'h8, 32'h21C,
                      3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("rs2_imm_no_stall", {31'b0, id_bus.stall}, 32'h0);
        applyStimulus(1'b1, 5'd1, 5'd7, 5'd0, 32'h0, 32'h0, 32'h8, 32'h21C,
                      3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("rs2_store_stall", {31'b0, id_bus.stall}, 32'h1);
        applyStimulus(1'b0, 5'd7, 5'd7, 5'd11, 32'h0, 32'h0, 32'h0, 32'h21C,
                      3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("id_invalid_no_stall", {31'b0, id_bus.stall}, 32'h0);

        // Reset in the middle of a stall drops the held instruction
        applyStimulus(1'b1, 5'd7, 5'd0, 5'd12, 32'h0, 32'h0, 32'h1, 32'h21C,
                      3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("pre_rst_stall", {31'b0, id_bus.stall}, 32'h1);
        checkOutput("pre_rst_aluop1", ALUop1, 32'h40);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_stall", {31'b0, id_bus.stall}, 32'h0);
        checkOutput("mid_rst_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("mid_rst_aluop1", ALUop1, 32'h0);
        checkOutput("mid_rst_mem_read", {31'b0, ex_mem_read}, 32'h0);
        idleDecode();
        step();
        rst = 1'b0;
        step();
        checkOutput("post_rst_valid", {31'b0, ex_valid}, 32'h0);

        // Back-to-back add x3 then sub reading x3
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0, 32'h300,
                      3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 5'd3, 5'd4, 5'd13, 32'h0, 32'h8, 32'h0, 32'h304,
                      3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("raw_stall_1", {31'b0, id_bus.stall}, FWD ? 32'h0 : 32'h1);
`ifdef EX_FWD_EN
        step();
        setExm(5'd3, 1'b1, 32'h30);
        idleDecode();
        #1;
        checkOutput("raw_sub_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("raw_sub_aluctrl", {29'b0, ALUctrl}, 32'h1);
        checkOutput("raw_sub_aluop1", ALUop1, 32'h30);
`else
        step();
        setExm(5'd3, 1'b1, 32'h30);
        #1;
        checkOutput("raw_stall_2", {31'b0, id_bus.stall}, 32'h1);
        checkOutput("raw_bubble_valid", {31'b0, ex_valid}, 32'h0);
        step();
        setExm(5'd0, 1'b0, 32'h0);
        setWb(5'd3, 1'b1, 32'h30);
        id_bus.id_rs1_data = 32'h30;
        #1;
        checkOutput("raw_stall_3", {31'b0, id_bus.stall}, 32'h0);
        step();
        idleDecode();
        setWb(5'd0, 1'b0, 32'h0);
        #1;
        checkOutput("raw_sub_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("raw_sub_aluctrl", {29'b0, ALUctrl}, 32'h1);
        checkOutput("raw_sub_aluop1", ALUop1, 32'h30);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
